// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: key synchronise/debounce, 4-state mode FSM,
// 10 ms tick prescaler, and counter-clear / display-load / LED control.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 500000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_display_stop,
  output logic       tick_10ms,
  output logic       count_clear,
  output logic       display_load,
  output logic [1:0] mode,
  output logic [3:0] led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  // Key index 0 = start/pause, 1 = display/stop; all key levels are active-low.
  logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         acc_q, acc_d, ev_q, ev_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               tick_q, tick_d;
  logic               clr_q, clr_d, clr_prev_q, clr_prev_d;
  logic               dl_q, dl_d, was_lap_q, was_lap_d;
  logic [3:0]         led_q, led_d;
  logic               sp_ev, ds_ev;

  always_comb begin
    sync1_d = {key_display_stop, key_start_pause};
    sync2_d = sync1_q;
    acc_d   = acc_q;
    cnt_d   = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != acc_q[k]) begin
        if (cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) acc_d[k] = ~acc_q[k];
        else                                       cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
    // Only the 1->0 flip of the accepted level is a press; release is silent.
    ev_d = acc_q & ~acc_d;
  end

  assign sp_ev = ev_q[0];
  assign ds_ev = ev_q[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sp_ev) state_d = S_RUN;
      S_RUN:   if (sp_ev) state_d = S_PAUSE; else if (ds_ev) state_d = S_LAP;
      S_LAP:   if (sp_ev) state_d = S_PAUSE; else if (ds_ev) state_d = S_RUN;
      S_PAUSE: if (sp_ev) state_d = S_RUN;   else if (ds_ev) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_q == S_RUN || state_q == S_LAP) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (state_d == S_IDLE) presc_d = '0;

    clr_d      = (state_q == S_PAUSE) && (state_d == S_IDLE);
    clr_prev_d = clr_q;
    was_lap_d  = (state_q == S_LAP);
    // Load after a live tick, after leaving LAP, or after the clear drops; never into LAP.
    dl_d = (state_d != S_LAP) &&
           (tick_q || (clr_prev_q && !clr_q) || (was_lap_q && state_q != S_LAP));

    case (state_d)
      S_IDLE:  led_d = 4'b1000;
      S_RUN:   led_d = 4'b0001;
      S_PAUSE: led_d = 4'b0100;
      S_LAP:   led_d = 4'b0011;
      default: led_d = 4'b1000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!key_reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      acc_q      <= 2'b11;
      ev_q       <= 2'b00;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      clr_q      <= 1'b1;
      clr_prev_q <= 1'b1;
      dl_q       <= 1'b0;
      was_lap_q  <= 1'b0;
      led_q      <= 4'b1000;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      acc_q      <= acc_d;
      ev_q       <= ev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      clr_q      <= clr_d;
      clr_prev_q <= clr_prev_d;
      dl_q       <= dl_d;
      was_lap_q  <= was_lap_d;
      led_q      <= led_d;
    end
  end

  assign tick_10ms    = tick_q;
  assign count_clear  = clr_q;
  assign display_load = dl_q;
  assign mode         = state_q;
  assign led          = led_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=5, DEBOUNCE_CYCLES=4: per-cycle
// scoreboard against a spec-level model plus directed latency/count checks.
module tb_stopwatch_ctrl;
  localparam int TD = 5;
  localparam int DB = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       key_reset, key_start_pause, key_display_stop;
  logic       tick_10ms, count_clear, display_load;
  logic [1:0] mode;
  logic [3:0] led;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk              (clk),
    .key_reset        (key_reset),
    .key_start_pause  (key_start_pause),
    .key_display_stop (key_display_stop),
    .tick_10ms        (tick_10ms),
    .count_clear      (count_clear),
    .display_load     (display_load),
    .mode             (mode),
    .led              (led)
  );

  int compared   = 0;
  int mismatched = 0;
  int tick_count = 0;
  int dl_count   = 0;
  logic [8:0] exp_q[$];

  // reference model state
  logic [1:0] m_s1, m_s2, m_acc, m_ev, m_state;
  int         m_run[2];
  int         m_presc;
  logic       m_tick, m_clr, m_dl, m_pend_clr, m_pend_lap;
  logic [3:0] m_led;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] led_of(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b1000;
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0100;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic model_step(input logic rst_n, input logic sp_n, input logic ds_n);
    logic [1:0] acc_new, ns;
    logic       tick_new, clr_new, dl_new;
    if (!rst_n) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_acc = 2'b11; m_ev = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_state = 2'b00; m_presc = 0; m_tick = 1'b0; m_clr = 1'b1; m_dl = 1'b0;
      m_pend_clr = 1'b0; m_pend_lap = 1'b0; m_led = 4'b1000;
      return;
    end
    // accepted level flips on the DB-th consecutive cycle of disagreement
    acc_new = m_acc;
    for (int k = 0; k < 2; k++) begin
      if (m_s2[k] != m_acc[k]) begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          acc_new[k] = ~m_acc[k];
          m_run[k]   = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    ns = m_state;
    if (m_ev[0]) begin
      case (m_state)
        2'b00:   ns = 2'b01;
        2'b01:   ns = 2'b10;
        2'b11:   ns = 2'b10;
        default: ns = 2'b01;
      endcase
    end else if (m_ev[1]) begin
      case (m_state)
        2'b01:   ns = 2'b11;
        2'b11:   ns = 2'b01;
        2'b10:   ns = 2'b00;
        default: ns = 2'b00;
      endcase
    end
    tick_new = 1'b0;
    if (m_state == 2'b01 || m_state == 2'b11) begin
      m_presc++;
      if (m_presc == TD) begin
        m_presc  = 0;
        tick_new = 1'b1;
      end
    end
    if (ns == 2'b00) m_presc = 0;
    clr_new    = (m_state == 2'b10) && (ns == 2'b00);
    dl_new     = (ns != 2'b11) && (m_tick || m_pend_clr || m_pend_lap);
    m_pend_clr = m_clr && !clr_new;
    m_pend_lap = (m_state == 2'b11) && (ns != 2'b11);
    m_ev    = m_acc & ~acc_new;
    m_acc   = acc_new;
    m_s2    = m_s1;
    m_s1    = {ds_n, sp_n};
    m_tick  = tick_new;
    m_clr   = clr_new;
    m_dl    = dl_new;
    m_state = ns;
    m_led   = led_of(ns);
  endtask

  // driver: apply inputs, push expected, clock, pop and compare
  task automatic drive_cycle(input logic rst_n, input logic sp_n, input logic ds_n);
    logic [8:0] exp, got;
    key_reset        = rst_n;
    key_start_pause  = sp_n;
    key_display_stop = ds_n;
    model_step(rst_n, sp_n, ds_n);
    exp_q.push_back({m_tick, m_clr, m_dl, m_state, m_led});
    @(posedge clk);
    #1;
    got = {tick_10ms, count_clear, display_load, mode, led};
    exp = exp_q.pop_front();
    check("cycle", 32'(got), 32'(exp));
    tick_count += int'(tick_10ms);
    dl_count   += int'(display_load);
  endtask

  task automatic idle(input int n);
    repeat (n) drive_cycle(1'b1, 1'b1, 1'b1);
  endtask

  task automatic wait_mode(input logic [1:0] tgt, input logic sp_n, input logic ds_n,
                           input int max_c, output int n);
    n = 0;
    do begin
      drive_cycle(1'b1, sp_n, ds_n);
      n++;
    end while (mode !== tgt && n < max_c);
  endtask

  task automatic wait_tick(input logic sp_n, input logic ds_n, input int max_c, output int n);
    n = 0;
    do begin
      drive_cycle(1'b1, sp_n, ds_n);
      n++;
    end while (tick_10ms !== 1'b1 && n < max_c);
  endtask

  initial begin
    int n, t0, d0;
    key_reset = 1'b0; key_start_pause = 1'b1; key_display_stop = 1'b1;

    // reset and release
    drive_cycle(1'b0, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_led", 32'(led), 32'h8);
    check("rst_clr", 32'(count_clear), 32'h1);
    check("rst_tick", 32'(tick_10ms), 32'h0);
    drive_cycle(1'b1, 1'b1, 1'b1);
    check("clr_release", 32'(count_clear), 32'h0);
    check("dl_early", 32'(display_load), 32'h0);
    drive_cycle(1'b1, 1'b1, 1'b1);
    check("dl_after_rst", 32'(display_load), 32'h1);
    drive_cycle(1'b1, 1'b1, 1'b1);
    check("dl_pulse_end", 32'(display_load), 32'h0);

    // bouncing start key in IDLE
    t0 = tick_count;
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, (i >= 3 && i < 6), 1'b1);
    idle(12);
    check("bounce_mode", 32'(mode), 32'h0);
    check("bounce_ticks", tick_count - t0, 0);

    // clean start: 12 cycles low
    wait_mode(2'b01, 1'b0, 1'b1, 30, n);
    check("start_lat", n, 7);
    wait_tick(1'b0, 1'b1, 30, n);
    check("first_tick", n, 5);
    for (int g = 0; g < 3; g++) begin
      drive_cycle(1'b1, 1'b1, 1'b1);
      check("dl_follow", 32'(display_load), 32'h1);
      wait_tick(1'b1, 1'b1, 30, n);
      check("tick_gap", n, 4);
    end
    idle(2);

    // lap and back
    wait_mode(2'b11, 1'b1, 1'b0, 30, n);
    check("lap_lat", n, 7);
    check("lap_led", 32'(led), 32'h3);
    t0 = tick_count; d0 = dl_count;
    for (int i = 0; i < 20; i++) drive_cycle(1'b1, 1'b1, (i >= 3));
    check("lap_ticks", tick_count - t0, 4);
    check("lap_dl", dl_count - d0, 0);
    wait_mode(2'b01, 1'b1, 1'b0, 30, n);
    check("unlap_lat", n, 7);
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("unlap_dl", 32'(display_load), 32'h1);
    idle(10);

    // pause with prescaler at 3, then resume
    n = 0;
    while (m_presc != 1 && n < 10) begin
      drive_cycle(1'b1, 1'b1, 1'b1);
      n++;
    end
    wait_mode(2'b10, 1'b0, 1'b1, 30, n);
    check("pause_lat", n, 7);
    check("pause_led", 32'(led), 32'h4);
    t0 = tick_count;
    for (int i = 0; i < 50; i++) drive_cycle(1'b1, (i >= 3), 1'b1);
    check("pause_ticks", tick_count - t0, 0);
    check("pause_hold", 32'(mode), 32'h2);
    wait_mode(2'b01, 1'b0, 1'b1, 30, n);
    check("resume_lat", n, 7);
    wait_tick(1'b0, 1'b1, 30, n);
    check("resume_tick", n, 2);
    idle(12);

    // simultaneous SP+DS, then clear back to IDLE
    wait_mode(2'b10, 1'b0, 1'b0, 30, n);
    check("both_lat", n, 7);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, (i >= 3), (i >= 3));
    check("both_mode", 32'(mode), 32'h2);
    wait_mode(2'b00, 1'b1, 1'b0, 30, n);
    check("clear_lat", n, 7);
    check("clear_on", 32'(count_clear), 32'h1);
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("clear_off", 32'(count_clear), 32'h0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("dl_after_clear", 32'(display_load), 32'h1);
    idle(10);
    wait_mode(2'b01, 1'b0, 1'b1, 30, n);
    check("restart_lat", n, 7);
    wait_tick(1'b0, 1'b1, 30, n);
    check("presc_cleared", n, 5);
    idle(3);

    // reset while running
    drive_cycle(1'b0, 1'b1, 1'b1);
    check("rerst_mode", 32'(mode), 32'h0);
    check("rerst_led", 32'(led), 32'h8);
    check("rerst_clr", 32'(count_clear), 32'h1);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
